multicycle_datapath: RTL and testbench
======================================

Name: multicycle_datapath

Overview:
Parametrised multicycle successor to the single-cycle ARM-subset datapath. One shared memory port serves both instruction and data through a valid/ready handshake. An internal phase FSM sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. The external control decoder supplies the same control bundle as before from the latched instruction; data width and PC width are generic.

Parameters:
DATA_W, 32, register/ALU/memory data width (>=24)
PC_W, 16, PC and memory address width (<=DATA_W)
PC_RESET, 0, PC value after reset (word aligned)
TIMEOUT_CYC, 64, memory wait limit (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
MemtoReg, ALUSrc, MemWrite, RegWrite, PCSrc  in  1 each  decoded controls, valid from DECODE onward
ImmSrc, RegSrc  in  2 each  immediate format / register-address selects
ALUControl  in  3  ALU operation
MemReady  in  1  memory accepts/completes current request
ReadData  in  DATA_W  memory read data, valid with MemReady
MemReq  out  1  memory request
MemAddr  out  PC_W  request address
MemWE  out  1  store request (qualifies MemReq)
WriteData  out  DATA_W  store data
Instr  out  32  instruction register
ALUFlags  out  4  latched NZCV
PC  out  PC_W  program counter
InstrDone  out  1  one-cycle pulse per retired instruction
Error  out  1  timeout flag (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (any state, any cycle): state<=FETCH, PC<=PC_RESET, Instr/A/B/ALUOut/DataReg<=0, ALUFlags<=0, all 16 registers<=0, MemReq/MemWE/InstrDone/Error<=0. An in-flight memory request is abandoned.
- FETCH: MemReq=1, MemWE=0, MemAddr=PC. On a cycle with MemReady=1: Instr<=ReadData[31:0], PC<=PC+4 (mod 2^PC_W), go to DECODE. Otherwise hold, with address stable.
- DECODE: RA1 = RegSrc[0] ? 15 : Instr[19:16]; RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0]. A<=RD1, B<=RD2. Reading R15 returns zero-extended PC+4; the PC is already incremented, so this equals instruction address+8.
- EXECUTE: SrcB = ALUSrc ? ExtImm : B. ALUOut<=ALU(A,SrcB), ALUFlags<=NZCV. This is the only phase that updates ALUFlags. Next state is MEM if MemWrite|MemtoReg, else WRITEBACK.
- ExtImm: ImmSrc 00 = zext Instr[7:0]; 01 = zext Instr[11:0]; 10 = sext(Instr[23:0])<<2; 11 = 0. All results are DATA_W wide.
- ALU ops: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV (SrcB), 110 CMP (SUB result, flags only), 111 reserved (result 0). C/V are defined for ADD/SUB/CMP only and are 0 for the others.
- MEM: MemReq=1, MemAddr=ALUOut[PC_W-1:0], MemWE=MemWrite, WriteData=B. Address and data are stable until MemReady=1. Then, for a load, DataReg<=ReadData; go to WRITEBACK.
- WRITEBACK: Result = MemtoReg ? DataReg : ALUOut. If RegWrite and Rd=Instr[15:12]!=15, write Result to Rd. If PCSrc, PC<=Result[PC_W-1:0] with bits [1:0] cleared; PCSrc wins over the FETCH increment. RegWrite with Rd=15 is ignored. InstrDone=1. Go to FETCH.
- MemReady is ignored while MemReq=0. MemReady may already be high in the first request cycle (zero-wait).
- Latency: non-memory instruction = 4 cycles + fetch waits; memory instruction = 5 cycles + all waits.
- Outside MEM, MemWE=0 and WriteData holds B.

Optional Feature:
MEM_TIMEOUT_EN. When defined, a counter clears on entry to FETCH or MEM and increments each waiting cycle. When it reaches TIMEOUT_CYC with MemReady still low: MemReq<=0, state<=ERROR, Error<=1. The block stays in ERROR until rst, with no register or PC updates. When undefined, there is no counter, the block waits indefinitely, and Error=0.

Decomposition:
- Shared package dp_pkg: phase enum (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, ERROR); ALU op codes; ImmSrc codes; flag bit indices N=3, Z=2, C=1, V=0; R15 index constant.
- One natural sub-module: mc_alu (combinational, DATA_W-parametrised, op + NZCV).
- Register file and phase FSM remain inside multicycle_datapath.

Test Plan:
- Reset: assert rst mid-MEM with MemReq=1 → next cycle PC=PC_RESET, MemReq=1, MemAddr=0, MemWE=0, ALUFlags=0.
- ADD immediate: R1=5, Instr=ADD R2,R1,#3 (ALUSrc=1, ImmSrc=00, RegWrite=1), zero-wait → R2=8 after 4 cycles, InstrDone once, PC=4.
- LDR with 2 wait states: R1=0x100, memory[0x104]=0xDEADBEEF → MemAddr=0x104 held 3 cycles, R3=0xDEADBEEF, total 7 cycles.
- STR and CMP flags: STR R2,[R1] → MemWE=1, WriteData=8. CMP R1,R1 → ALUFlags=4'b0110, no register written.
- Branch: PC=0x20, offset field=2, PCSrc=1, ALU ADD of R15 and ExtImm → PC=0x30, next fetch MemAddr=0x30.
- With MEM_TIMEOUT_EN, TIMEOUT_CYC=8, MemReady held low in FETCH → Error=1 after 8 cycles, MemReq=0, PC unchanged until rst.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the multicycle ARM-subset datapath: instruction
// phases, ALU operation codes, immediate formats and NZCV flag positions.
package dp_pkg;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4,
      ERROR     = 3'd5
   } phase_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;
   localparam logic [2:0] ALU_MOV = 3'b101;
   localparam logic [2:0] ALU_CMP = 3'b110;
   localparam logic [2:0] ALU_RSV = 3'b111;

   localparam logic [1:0] IMM_8    = 2'b00;
   localparam logic [1:0] IMM_12   = 2'b01;
   localparam logic [1:0] IMM_BR   = 2'b10;
   localparam logic [1:0] IMM_ZERO = 2'b11;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] R15 = 4'd15;

endpackage

// File: rtl/multicycle_datapath_alu.sv
// mc_alu: combinational DATA_W-wide ALU producing a result and NZCV flags.
// Carry follows the ARM convention: for subtraction C=1 means no borrow.
module mc_alu
   import dp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;
   logic            carry;
   logic            overflow;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

   // Select the operation result; C and V only carry meaning for add/subtract
   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
         ALU_ADD: begin
            result   = sum[DATA_W-1:0];
            carry    = sum[DATA_W];
            overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         ALU_SUB, ALU_CMP: begin
            result   = diff[DATA_W-1:0];
            carry    = diff[DATA_W];
            overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         ALU_AND: result = a & b;
         ALU_ORR: result = a | b;
         ALU_EOR: result = a ^ b;
         ALU_MOV: result = b;
         default: result = '0;
      endcase
   end

   // Pack the NZCV nibble from the selected result
   always_comb begin
      flags         = '0;
      flags[FLAG_N] = result[MSB];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = overflow;
   end

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: ARM-subset datapath sequenced through FETCH, DECODE,
// EXECUTE, MEM and WRITEBACK over one shared valid/ready memory port.
// Optional feature macro: MEM_TIMEOUT_EN (memory wait watchdog -> ERROR).
module multicycle_datapath
   import dp_pkg::*;
#(
   parameter int              DATA_W      = 32,
   parameter int              PC_W        = 16,
   parameter logic [PC_W-1:0] PC_RESET    = '0,
   parameter int              TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemtoReg,
   input  logic              ALUSrc,
   input  logic              MemWrite,
   input  logic              RegWrite,
   input  logic              PCSrc,
   input  logic [1:0]        ImmSrc,
   input  logic [1:0]        RegSrc,
   input  logic [2:0]        ALUControl,
   input  logic              MemReady,
   input  logic [DATA_W-1:0] ReadData,
   output logic              MemReq,
   output logic [PC_W-1:0]   MemAddr,
   output logic              MemWE,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       Instr,
   output logic [3:0]        ALUFlags,
   output logic [PC_W-1:0]   PC,
   output logic              InstrDone,
   output logic              Error
);

   phase_t            state;
   logic [DATA_W-1:0] regs [16];
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] data_reg;

   logic [3:0]        ra1;
   logic [3:0]        ra2;
   logic [3:0]        rd;
   logic [PC_W-1:0]   pc_plus4;
   logic [DATA_W-1:0] r15_val;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] ext_imm;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_flags;
   logic [DATA_W-1:0] result;
   logic [PC_W-1:0]   branch_pc;

   // Register read: R15 is not stored, it reads as the already-incremented
   // PC plus 4, i.e. the current instruction address plus 8
   assign ra1      = RegSrc[0] ? R15 : Instr[19:16];
   assign ra2      = RegSrc[1] ? Instr[15:12] : Instr[3:0];
   assign rd       = Instr[15:12];
   assign pc_plus4 = PC + PC_W'(4);
   assign r15_val  = DATA_W'(pc_plus4);
   assign rd1      = (ra1 == R15) ? r15_val : regs[ra1];
   assign rd2      = (ra2 == R15) ? r15_val : regs[ra2];

   // Immediate extension; the branch form is a signed word offset
   always_comb begin
      ext_imm = '0;
      case (ImmSrc)
         IMM_8:   ext_imm = DATA_W'(Instr[7:0]);
         IMM_12:  ext_imm = DATA_W'(Instr[11:0]);
         IMM_BR:  ext_imm = DATA_W'($signed(Instr[23:0])) << 2;
         default: ext_imm = '0;
      endcase
   end

   assign src_b = ALUSrc ? ext_imm : b_reg;

   mc_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (a_reg),
      .b      (src_b),
      .op     (ALUControl),
      .result (alu_result),
      .flags  (alu_flags)
   );

   assign result    = MemtoReg ? data_reg : alu_out;
   assign branch_pc = {result[PC_W-1:2], 2'b00};

   // Memory port and retire pulse decode straight from the phase register,
   // so they change only on clock edges and an address never moves mid-wait
   assign MemReq    = (state == FETCH) || (state == MEM);
   assign MemAddr   = (state == MEM) ? alu_out[PC_W-1:0] : PC;
   assign MemWE     = (state == MEM) && MemWrite;
   assign WriteData = b_reg;
   assign InstrDone = (state == WRITEBACK);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_reg;
   logic             timed_out;

   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign Error     = err_reg;
`else
   assign Error = 1'b0;
`endif

   // Phase FSM with all architectural state; reset abandons any request
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         PC       <= PC_RESET;
         Instr    <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         alu_out  <= '0;
         data_reg <= '0;
         ALUFlags <= '0;
         for (int i = 0; i < 16; i++) begin
            regs[i] <= '0;
         end
`ifdef MEM_TIMEOUT_EN
         wait_cnt <= '0;
         err_reg  <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (MemReady) begin
                  Instr <= ReadData[31:0];
                  PC    <= pc_plus4;
                  state <= DECODE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (timed_out) begin
                  state   <= ERROR;
                  err_reg <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            DECODE: begin
               a_reg <= rd1;
               b_reg <= rd2;
               state <= EXECUTE;
            end
            EXECUTE: begin
               alu_out  <= alu_result;
               ALUFlags <= alu_flags;
               if (MemWrite || MemtoReg) begin
                  state <= MEM;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else begin
                  state <= WRITEBACK;
               end
            end
            MEM: begin
               if (MemReady) begin
                  if (MemtoReg) begin
                     data_reg <= ReadData;
                  end
                  state <= WRITEBACK;
               end
`ifdef MEM_TIMEOUT_EN
               else if (timed_out) begin
                  state   <= ERROR;
                  err_reg <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            WRITEBACK: begin
               if (RegWrite && (rd != R15)) begin
                  regs[rd] <= result;
               end
               if (PCSrc) begin
                  PC <= branch_pc;
               end
               state <= FETCH;
`ifdef MEM_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ERROR: begin
               state <= ERROR;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed vector bench for multicycle_datapath.
// The bench plays both the control decoder and the shared memory.
// With MEM_TIMEOUT_EN defined the final sequence expects the watchdog to trip.
module tb_multicycle_datapath;

   localparam int DATA_W      = 32;
   localparam int PC_W        = 16;
   localparam int TIMEOUT_CYC = 8;

   logic              clk;
   logic              rst;
   logic              MemtoReg;
   logic              ALUSrc;
   logic              MemWrite;
   logic              RegWrite;
   logic              PCSrc;
   logic [1:0]        ImmSrc;
   logic [1:0]        RegSrc;
   logic [2:0]        ALUControl;
   logic              MemReady;
   logic [DATA_W-1:0] ReadData;
   logic              MemReq;
   logic [PC_W-1:0]   MemAddr;
   logic              MemWE;
   logic [DATA_W-1:0] WriteData;
   logic [31:0]       Instr;
   logic [3:0]        ALUFlags;
   logic [PC_W-1:0]   PC;
   logic              InstrDone;
   logic              Error;

   int checkCount;
   int errorCount;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  alu;
      logic        aluSrc;
      logic [1:0]  immSrc;
      logic [1:0]  regSrc;
      logic        memToReg;
      logic        memWrite;
      logic        regWrite;
      logic        pcSrc;
      int          fetchWait;
      int          memWait;
      logic [31:0] rdata;
      int          expCycles;
      logic [15:0] expMemAddr;
      logic [31:0] expWdata;
      logic [3:0]  expFlags;
      logic [15:0] expPc;
   } vec_t;

   vec_t vecs [12];
   vec_t postReset;

   multicycle_datapath #(
      .DATA_W      (DATA_W),
      .PC_W        (PC_W),
      .PC_RESET    (16'h0000),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MemtoReg   (MemtoReg),
      .ALUSrc     (ALUSrc),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .PCSrc      (PCSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .MemReady   (MemReady),
      .ReadData   (ReadData),
      .MemReq     (MemReq),
      .MemAddr    (MemAddr),
      .MemWE      (MemWE),
      .WriteData  (WriteData),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .PC         (PC),
      .InstrDone  (InstrDone),
      .Error      (Error)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence wedges outside its own cycle bounds
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   function automatic vec_t mkVec(
      input logic [31:0] instr, input logic [2:0] alu, input logic aluSrc,
      input logic [1:0] immSrc, input logic [1:0] regSrc, input logic memToReg,
      input logic memWrite, input logic regWrite, input logic pcSrc,
      input int fetchWait, input int memWait, input logic [31:0] rdata,
      input int expCycles, input logic [15:0] expMemAddr, input logic [31:0] expWdata,
      input logic [3:0] expFlags, input logic [15:0] expPc);
      vec_t v;
      v.instr = instr;           v.alu = alu;             v.aluSrc = aluSrc;
      v.immSrc = immSrc;         v.regSrc = regSrc;       v.memToReg = memToReg;
      v.memWrite = memWrite;     v.regWrite = regWrite;   v.pcSrc = pcSrc;
      v.fetchWait = fetchWait;   v.memWait = memWait;     v.rdata = rdata;
      v.expCycles = expCycles;   v.expMemAddr = expMemAddr;
      v.expWdata = expWdata;     v.expFlags = expFlags;   v.expPc = expPc;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one instruction from FETCH to retirement, acting as decoder and
   // memory, then compare timing, memory traffic, flags and the next PC
   task automatic applyStimulus(input string tag, input vec_t v);
      int          fw;
      int          mw;
      int          cycles;
      int          memCycles;
      logic        fetched;
      logic        doneSeen;
      logic        stable;
      logic [15:0] memAddrSeen;
      logic        weSeen;
      logic [31:0] wdataSeen;
      ALUControl = v.alu;      ALUSrc   = v.aluSrc;   ImmSrc   = v.immSrc;
      RegSrc     = v.regSrc;   MemtoReg = v.memToReg; MemWrite = v.memWrite;
      RegWrite   = v.regWrite; PCSrc    = v.pcSrc;
      fw = v.fetchWait;  mw = v.memWait;
      cycles = 0;  memCycles = 0;  fetched = 1'b0;  doneSeen = 1'b0;  stable = 1'b1;
      memAddrSeen = '0;  weSeen = 1'b0;  wdataSeen = '0;
      for (int k = 0; k < 40 && !doneSeen; k++) begin
         cycles++;
         if (MemReq) begin
            if (!fetched) begin
               if (fw > 0) begin
                  MemReady = 1'b0;  fw--;
               end else begin
                  MemReady = 1'b1;  ReadData = v.instr;  fetched = 1'b1;
               end
            end else begin
               if (memCycles == 0) begin
                  memAddrSeen = MemAddr;  weSeen = MemWE;  wdataSeen = WriteData;
               end else if (MemAddr !== memAddrSeen || MemWE !== weSeen ||
                            WriteData !== wdataSeen) begin
                  stable = 1'b0;
               end
               memCycles++;
               if (mw > 0) begin
                  MemReady = 1'b0;  mw--;
               end else begin
                  MemReady = 1'b1;  ReadData = v.rdata;
               end
            end
         end else begin
            MemReady = 1'b1;
            ReadData = 32'hBAD0_BAD0;
         end
         if (InstrDone) doneSeen = 1'b1;
         tick();
      end
      MemReady = 1'b0;
      checkOutput({tag, ".retired"}, {31'b0, doneSeen}, 32'd1);
      checkOutput({tag, ".cycles"}, cycles, v.expCycles);
      checkOutput({tag, ".flags"}, {28'b0, ALUFlags}, {28'b0, v.expFlags});
      checkOutput({tag, ".pc"}, {16'b0, PC}, {16'b0, v.expPc});
      checkOutput({tag, ".next_fetch"}, {15'b0, MemReq, MemAddr}, {15'b0, 1'b1, v.expPc});
      checkOutput({tag, ".done_pulse"}, {31'b0, InstrDone}, 32'd0);
      if (v.memWrite || v.memToReg) begin
         checkOutput({tag, ".mem_cycles"}, memCycles, v.memWait + 1);
         checkOutput({tag, ".mem_stable"}, {31'b0, stable}, 32'd1);
         checkOutput({tag, ".mem_addr"}, {16'b0, memAddrSeen}, {16'b0, v.expMemAddr});
         checkOutput({tag, ".mem_we"}, {31'b0, weSeen}, {31'b0, v.memWrite});
         if (v.memWrite) begin
            checkOutput({tag, ".wdata"}, wdataSeen, v.expWdata);
         end
      end
   endtask

   initial begin
      logic        stable;
      logic        expErr;
      logic [15:0] heldPc;
      checkCount = 0;
      errorCount = 0;
      rst = 1'b1;  MemReady = 1'b0;  ReadData = '0;
      MemtoReg = 1'b0;  ALUSrc = 1'b0;  MemWrite = 1'b0;  RegWrite = 1'b0;
      PCSrc = 1'b0;  ImmSrc = 2'b00;  RegSrc = 2'b00;  ALUControl = 3'b000;

      //           instr         alu     src immS   regS  m2r mw  rw  pcs fw mw rdata          cyc addr     wdata          flags    pc
      vecs[0]  = mkVec(32'hE3A01005, 3'b101, 1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 32'h0,          4, 16'h0,    32'h0,         4'b0000, 16'h0004);
      vecs[1]  = mkVec(32'hE2812003, 3'b000, 1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 32'h0,          4, 16'h0,    32'h0,         4'b0000, 16'h0008);
      vecs[2]  = mkVec(32'hE5812000, 3'b000, 1, 2'b01, 2'b10, 0, 1, 0, 0, 0, 0, 32'h0,          5, 16'h0005, 32'h8,         4'b0000, 16'h000C);
      vecs[3]  = mkVec(32'hE1510001, 3'b110, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0,          4, 16'h0,    32'h0,         4'b0110, 16'h0010);
      vecs[4]  = mkVec(32'hE3A01100, 3'b101, 1, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 32'h0,          4, 16'h0,    32'h0,         4'b0000, 16'h0014);
      vecs[5]  = mkVec(32'hE5913004, 3'b000, 1, 2'b01, 2'b10, 1, 0, 1, 0, 0, 2, 32'hDEADBEEF,   7, 16'h0104, 32'h0,         4'b0000, 16'h0018);
      vecs[6]  = mkVec(32'hE5813000, 3'b000, 1, 2'b01, 2'b10, 0, 1, 0, 0, 1, 1, 32'h0,          7, 16'h0100, 32'hDEADBEEF,  4'b0000, 16'h001C);
      vecs[7]  = mkVec(32'hE0424001, 3'b001, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 32'h0,          4, 16'h0,    32'h0,         4'b1000, 16'h0020);
      vecs[8]  = mkVec(32'hEA000002, 3'b000, 1, 2'b10, 2'b01, 0, 0, 0, 1, 0, 0, 32'h0,          4, 16'h0,    32'h0,         4'b0000, 16'h0030);
      vecs[9]  = mkVec(32'hE5824000, 3'b000, 1, 2'b01, 2'b10, 0, 1, 0, 0, 0, 0, 32'h0,          5, 16'h0008, 32'hFFFFFF08,  4'b0000, 16'h0034);
      vecs[10] = mkVec(32'hE0846004, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 0, 2, 0, 32'h0,          6, 16'h0,    32'h0,         4'b1010, 16'h0038);
      vecs[11] = mkVec(32'hE5816000, 3'b000, 1, 2'b01, 2'b10, 0, 1, 0, 0, 0, 3, 32'h0,          8, 16'h0100, 32'hFFFFFE10,  4'b0000, 16'h003C);
      postReset = mkVec(32'hE5816000, 3'b000, 1, 2'b01, 2'b10, 0, 1, 0, 0, 0, 0, 32'h0,        5, 16'h0000, 32'h0,         4'b0100, 16'h0004);

      $display("[TB] reset state");
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset.pc", {16'b0, PC}, 32'h0);
      checkOutput("reset.memreq", {31'b0, MemReq}, 32'd1);
      checkOutput("reset.memaddr", {16'b0, MemAddr}, 32'h0);
      checkOutput("reset.memwe", {31'b0, MemWE}, 32'd0);
      checkOutput("reset.flags", {28'b0, ALUFlags}, 32'h0);
      checkOutput("reset.instr", Instr, 32'h0);
      checkOutput("reset.done", {31'b0, InstrDone}, 32'd0);
      checkOutput("reset.error", {31'b0, Error}, 32'd0);

      $display("[TB] program vectors");
      for (int i = 0; i < 12; i++) begin
         applyStimulus($sformatf("v%0d", i), vecs[i]);
      end

      // Reset while a store is stalled in MEM: STR R4,[R4] leaves N set
      $display("[TB] reset during MEM");
      ALUControl = 3'b000;  ALUSrc = 1'b1;  ImmSrc = 2'b01;  RegSrc = 2'b10;
      MemtoReg = 1'b0;  MemWrite = 1'b1;  RegWrite = 1'b0;  PCSrc = 1'b0;
      MemReady = 1'b1;  ReadData = 32'hE5844000;
      tick();
      tick();
      tick();
      MemReady = 1'b0;
      checkOutput("midmem.memreq", {31'b0, MemReq}, 32'd1);
      checkOutput("midmem.memwe", {31'b0, MemWE}, 32'd1);
      checkOutput("midmem.addr", {16'b0, MemAddr}, 32'h0000FF08);
      checkOutput("midmem.flags", {28'b0, ALUFlags}, 32'h8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rstmem.pc", {16'b0, PC}, 32'h0);
      checkOutput("rstmem.memreq", {31'b0, MemReq}, 32'd1);
      checkOutput("rstmem.memaddr", {16'b0, MemAddr}, 32'h0);
      checkOutput("rstmem.memwe", {31'b0, MemWE}, 32'd0);
      checkOutput("rstmem.flags", {28'b0, ALUFlags}, 32'h0);
      applyStimulus("postrst", postReset);

      // Fetch starved of MemReady: stalls forever, or trips the watchdog
`ifdef MEM_TIMEOUT_EN
      expErr = 1'b1;
`else
      expErr = 1'b0;
`endif
      $display("[TB] fetch starvation");
      MemReady = 1'b0;
      heldPc = PC;
      stable = 1'b1;
      for (int k = 0; k < TIMEOUT_CYC - 1; k++) begin
         tick();
         if (MemReq !== 1'b1 || MemAddr !== heldPc || Error !== 1'b0) stable = 1'b0;
      end
      checkOutput("starve.before_limit", {31'b0, stable}, 32'd1);
      tick();
      checkOutput("starve.error", {31'b0, Error}, {31'b0, expErr});
      checkOutput("starve.memreq", {31'b0, MemReq}, {31'b0, ~expErr});
      MemReady = 1'b1;
      ReadData = 32'hE3A01005;
      tick();
      tick();
      checkOutput("starve.pc", {16'b0, PC}, expErr ? {16'b0, heldPc} : {16'b0, heldPc} + 32'd4);
      checkOutput("starve.error_hold", {31'b0, Error}, {31'b0, expErr});
      MemReady = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("final.error", {31'b0, Error}, 32'd0);
      checkOutput("final.pc", {16'b0, PC}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
